// File: rtl/snow_pkg.sv
// snow_pkg: GF(2^8) helpers, the AES S-box and the SNOW 2.0 MixColumn.
// Shared by the S-transform word slice and the pipeline top.
package snow_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox8(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Byte 3 (msb) is s0; rows of the circulant (2 3 1 1).
    function automatic logic [31:0] mix_col32(input logic [31:0] s);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = s;
        return {
            xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)
        };
    endfunction

endpackage

// File: rtl/snow_s_word.sv
// snow_s_word: combinational S-transform of one 32-bit word.
// Mode 0 is the byte S-box only; mode 1 adds the MixColumn.
module snow_s_word
    import snow_pkg::*;
(
    input  logic        i_mode,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [31:0] w_sub;

    always_comb begin
        w_sub = '0;
        for (int j = 0; j < 4; j++) begin
            w_sub[8*j +: 8] = sbox8(i_data[8*j +: 8]);
        end
    end

    assign o_data = i_mode ? mix_col32(w_sub) : w_sub;

endmodule

// File: rtl/snow_s_pipe.sv
// snow_s_pipe: handshaked SNOW 2.0 S-transform over LANES words.
// One or two register stages with a ripple-back stall enable.
module snow_s_pipe
    import snow_pkg::*;
#(
    parameter int LANES   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data
);

    localparam int W = 32 * LANES;

    logic         r_v1;
    logic         r_m1;
    logic [W-1:0] r_d1;
    logic [W-1:0] w_xf;
    logic         w_en1;

    assign in_ready = w_en1 & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            r_d1 <= in_data;
            r_m1 <= in_mode;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        snow_s_word u_word (
            .i_mode (r_m1),
            .i_data (r_d1[32*k +: 32]),
            .o_data (w_xf[32*k +: 32])
        );
    end

    if (OUT_REG) begin : g_s2
        logic         r_v2;
        logic [W-1:0] r_d2;
        logic         w_en2;

        assign w_en2 = ~r_v2 | out_ready;
        assign w_en1 = ~r_v1 | w_en2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2 <= 1'b0;
            end else if (w_en2) begin
                r_v2 <= r_v1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_en2 && r_v1) begin
                r_d2 <= w_xf;
            end
        end

        assign out_valid = r_v2 & ~rst;
        assign out_data  = out_valid ? r_d2 : '0;
    end else begin : g_comb
        assign w_en1     = ~r_v1 | out_ready;
        assign out_valid = r_v1 & ~rst;
        assign out_data  = out_valid ? w_xf : '0;
    end

endmodule

// File: tb/tb_snow_s_pipe.sv
// tb_snow_s_pipe: vectors, streaming, stall, reset and lane checks
// against a GF(2^8) reference built from the field definition.
module tb_snow_s_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_iv, a_ir, a_md, a_ov, a_or;
    logic [31:0]  a_id, a_od;
    logic         b_iv, b_ir, b_md, b_ov, b_or;
    logic [127:0] b_id, b_od;

    snow_s_pipe u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_mode(a_md), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_od)
    );

    snow_s_pipe #(.LANES(4), .OUT_REG(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_mode(b_md), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_od)
    );

    int n_run = 0;
    int n_fail = 0;
    logic [7:0] sb [256];

    logic [31:0]  qa [$];
    logic [127:0] qb [$];
    bit           a_hold, b_hold;
    logic [31:0]  a_hold_d;
    logic [127:0] b_hold_d;

    typedef struct {
        logic        md;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_word(input logic md, input logic [31:0] w);
        logic [7:0] s [4];
        logic [7:0] r [4];
        logic [7:0] c;
        for (int i = 0; i < 4; i++) s[i] = sb[w[31-8*i -: 8]];
        if (!md) return {s[0], s[1], s[2], s[3]};
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                case ((j - i + 4) % 4)
                    0: c = 8'h02;
                    1: c = 8'h03;
                    default: c = 8'h01;
                endcase
                r[i] = r[i] ^ gmul(c, s[j]);
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [127:0] ref_beat(input logic md, input logic [127:0] d);
        logic [127:0] o;
        for (int k = 0; k < 4; k++) o[32*k +: 32] = ref_word(md, d[32*k +: 32]);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step_a(input bit iv, input logic md, input logic [31:0] d,
                          input bit ordy, output bit acc);
        @(negedge clk);
        a_iv = iv; a_md = md; a_id = d; a_or = ordy;
        #1;
        if (a_hold) begin
            chk("a_held_valid", a_ov, 1);
            chk("a_held_data", a_od, a_hold_d);
        end
        if (a_ov && a_or) begin
            if (qa.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL a_spurious: got %h expected no beat", a_od);
            end else begin
                chk("a_data", a_od, qa.pop_front());
            end
        end
        acc = a_iv && a_ir;
        if (acc) qa.push_back(ref_word(md, d));
        a_hold = a_ov && !a_or;
        a_hold_d = a_od;
    endtask

    task automatic step_b(input bit iv, input logic md, input logic [127:0] d,
                          input bit ordy);
        @(negedge clk);
        b_iv = iv; b_md = md; b_id = d; b_or = ordy;
        #1;
        if (b_hold) begin
            chk("b_held_valid", b_ov, 1);
            chk("b_held_data", b_od, b_hold_d);
        end
        if (b_ov && b_or) begin
            if (qb.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL b_spurious: got %h expected no beat", b_od);
            end else begin
                chk("b_data", b_od, qb.pop_front());
            end
        end
        if (b_iv && b_ir) qb.push_back(ref_beat(md, d));
        b_hold = b_ov && !b_or;
        b_hold_d = b_od;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [6];
        logic [31:0] bd [12];
        logic        bm [12];
        logic [7:0]  inv, b;
        int          idx;
        bit          acc;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                      ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        vt[0] = '{1'b0, 32'h00010203, 32'h637C777B};
        vt[1] = '{1'b1, 32'h00000000, 32'h63636363};
        vt[2] = '{1'b1, 32'h9F825068, 32'h8E4DA1BC};
        vt[3] = '{1'b0, 32'h9F825068, 32'hDB135345};
        vt[4] = '{1'b0, 32'hFFFFFFFF, 32'h16161616};
        vt[5] = '{1'b1, 32'h01010101, 32'h7C7C7C7C};

        rst = 1'b1;
        a_iv = 0; a_md = 0; a_id = '0; a_or = 1;
        b_iv = 0; b_md = 0; b_id = '0; b_or = 1;
        a_hold = 0; b_hold = 0;
        repeat (3) @(negedge clk);
        a_iv = 1;
        #1;
        chk("rst_a_valid", a_ov, 0);
        chk("rst_a_data", a_od, 0);
        chk("rst_a_ready", a_ir, 0);
        chk("rst_b_ready", b_ir, 0);
        chk("rst_b_data", b_od, 0);
        @(negedge clk);
        rst = 1'b0; a_iv = 0;
        #1;
        chk("post_rst_a_ready", a_ir, 1);
        chk("post_rst_b_ready", b_ir, 1);
        chk("post_rst_a_valid", a_ov, 0);

        foreach (vt[i]) begin
            step_a(1, vt[i].md, vt[i].din, 1, acc);
            chk("vec_accept", acc, 1);
            step_a(0, 0, 0, 1, acc);
            chk("vec_lat_not1", a_ov, 0);
            step_a(0, 0, 0, 1, acc);
            chk("vec_lat2", a_ov, 1);
            chk("vec_out", a_od, vt[i].exp);
        end

        for (int j = 0; j < 20; j++) begin
            step_a(j < 16, j % 2 == 1, $urandom, 1, acc);
            if (j < 16) chk("stream_ready", a_ir, 1);
            chk("stream_valid", a_ov, j >= 2 && j < 18);
        end
        chk("stream_drain", qa.size(), 0);

        for (int i = 0; i < 12; i++) begin
            bd[i] = $urandom;
            bm[i] = 1'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            step_a(idx < 12, idx < 12 ? bm[idx] : 1'b0,
                   idx < 12 ? bd[idx] : 32'h0, !(c >= 4 && c < 9), acc);
            if (c >= 5 && c < 9) chk("bp_ready_low", a_ir, 0);
            if (acc) idx++;
        end
        chk("bp_all_sent", idx, 12);
        chk("bp_drain", qa.size(), 0);

        step_a(1, 0, $urandom, 0, acc);
        step_a(1, 1, $urandom, 0, acc);
        chk("rst_inflight", qa.size(), 2);
        @(negedge clk);
        rst = 1'b1; a_iv = 1; a_or = 1;
        #1;
        chk("midrst_valid", a_ov, 0);
        chk("midrst_ready", a_ir, 0);
        qa.delete();
        a_hold = 0;
        @(negedge clk);
        rst = 1'b0; a_iv = 0;
        #1;
        chk("midrst_after_valid", a_ov, 0);
        chk("midrst_after_ready", a_ir, 1);
        step_a(1, 1, 32'h9F825068, 1, acc);
        repeat (4) step_a(0, 0, 0, 1, acc);
        chk("midrst_new_beat", qa.size(), 0);

        for (int c = 0; c < 300; c++)
            step_a($urandom % 4 != 0, 1'($urandom), $urandom, $urandom % 3 != 0, acc);
        repeat (4) step_a(0, 0, 0, 1, acc);
        chk("rand_a_drain", qa.size(), 0);
        a_iv = 0;

        for (int j = 0; j < 12; j++) begin
            step_b(j < 10, j % 2 == 1, r128(), 1);
            if (j < 10) chk("b_ready", b_ir, 1);
            chk("b_lat1_valid", b_ov, j >= 1 && j < 11);
        end
        for (int c = 0; c < 200; c++)
            step_b($urandom % 4 != 0, 1'($urandom), r128(), $urandom % 3 != 0);
        repeat (3) step_b(0, 0, '0, 1);
        chk("rand_b_drain", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
